// File: rtl/ecc_scrub_pkg.sv
// Shared types for the ECC scrub scheduler: FSM states and port-owner encoding.
package ecc_scrub_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    CHECK,
    WB
  } scrub_state_e;

  localparam logic SRC_HOST  = 1'b0;
  localparam logic SRC_SCRUB = 1'b1;

endpackage

// File: rtl/ecc_scrub_scheduler_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 q <= '0;
    else if (clr)            q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
  end

endmodule

// File: rtl/ecc_scrub_scheduler.sv
// Single-port arbiter between host traffic and a periodic ECC scrubber that
// reads every row, writes back corrected data on SEC and logs DED events.
module ecc_scrub_scheduler
  import ecc_scrub_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int INTERVAL  = 1024,
  parameter int MAX_DEFER = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_gnt,
  input  logic              scrub_en,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wb_sel,
  input  logic              ecc_valid,
  input  logic              ecc_sec,
  input  logic              ecc_ded,
  output logic              scrub_busy,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count,
  output logic              ded_irq,
  output logic [ADDR_W-1:0] ded_addr
);

  localparam int IVL_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam int DEF_W = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;
  localparam logic [IVL_W-1:0] IVL_LAST = IVL_W'(INTERVAL - 1);
  localparam logic [DEF_W-1:0] DEF_MAX  = DEF_W'(MAX_DEFER);

  scrub_state_e      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [IVL_W-1:0]  ivl_q, ivl_d;
  logic [DEF_W-1:0]  defer_q, defer_d;
  logic              irq_d;
  logic [ADDR_W-1:0] ded_addr_d;
  logic              sec_inc, ded_inc;

  logic scrub_want, scrub_slot, src, host_wr_hit;

  // Host owns the port unless the scrubber has been starved for MAX_DEFER cycles.
  assign scrub_want  = (state_q == READ) || (state_q == WB);
  assign scrub_slot  = scrub_want && (!host_req || defer_q == DEF_MAX);
  assign host_gnt    = host_req && !scrub_slot && !rst;
  assign src         = scrub_slot ? SRC_SCRUB : SRC_HOST;
  assign mem_en      = host_gnt || scrub_slot;
  assign mem_we      = (src == SRC_SCRUB) ? (state_q == WB) : (host_gnt && host_we);
  assign mem_addr    = (src == SRC_SCRUB) ? ptr_q : (host_gnt ? host_addr : '0);
  assign mem_wb_sel  = (src == SRC_SCRUB) && (state_q == WB);
  assign scrub_busy  = (state_q != IDLE) && (state_q != WAIT);
  // A granted host write to the scrub row supersedes the pending correction.
  assign host_wr_hit = host_gnt && host_we && (host_addr == ptr_q);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ivl_d      = ivl_q;
    defer_d    = defer_q;
    irq_d      = 1'b0;
    ded_addr_d = ded_addr;
    sec_inc    = 1'b0;
    ded_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (scrub_en) begin
          state_d = WAIT;
          ivl_d   = '0;
        end
      end
      WAIT: begin
        if (!scrub_en) begin
          state_d = IDLE;
          ivl_d   = '0;
        end else if (ivl_q == IVL_LAST) begin
          state_d = READ;
          ivl_d   = '0;
        end else begin
          ivl_d = ivl_q + 1'b1;
        end
      end
      READ: begin
        if (scrub_slot) begin
          state_d = CHECK;
          defer_d = '0;
        end else begin
          defer_d = defer_q + 1'b1;
        end
      end
      CHECK: begin
        // Missing ecc_valid is treated as a clean read; DED outranks SEC.
        state_d = WAIT;
        ptr_d   = ptr_q + 1'b1;
        if (ecc_valid && ecc_ded) begin
          ded_inc    = 1'b1;
          irq_d      = 1'b1;
          ded_addr_d = ptr_q;
        end else if (ecc_valid && ecc_sec) begin
          sec_inc = 1'b1;
          if (!host_wr_hit) begin
            state_d = WB;
            ptr_d   = ptr_q;
          end
        end
      end
      WB: begin
        if (scrub_slot || host_wr_hit) begin
          state_d = WAIT;
          ptr_d   = ptr_q + 1'b1;
          defer_d = '0;
        end else begin
          defer_d = defer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      ivl_q    <= '0;
      defer_q  <= '0;
      ded_irq  <= 1'b0;
      ded_addr <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ivl_q    <= ivl_d;
      defer_q  <= defer_d;
      ded_irq  <= irq_d;
      ded_addr <= ded_addr_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_sec_cnt (
    .clk (clk),
    .rst (rst),
    .inc (sec_inc),
    .clr (1'b0),
    .q   (sec_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ded_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ded_inc),
    .clr (1'b0),
    .q   (ded_count)
  );

endmodule

// File: tb/tb_ecc_scrub_scheduler.sv
// Directed scenarios followed by randomized host/ECC traffic checked against a
// transaction-level model of scrub ordering, write-back and error logging.
module tb_ecc_scrub_scheduler;

  localparam int ADDR_W    = 7;
  localparam int INTERVAL  = 4;
  localparam int MAX_DEFER = 16;
  localparam int CNT_W     = 4;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int SAT       = (1 << CNT_W) - 1;
  localparam int FORCE_I   = 1 + INTERVAL + MAX_DEFER;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              host_req = 1'b0, host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic              host_gnt;
  logic              scrub_en = 1'b0;
  logic              mem_en, mem_we, mem_wb_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic              ecc_valid = 1'b0, ecc_sec = 1'b0, ecc_ded = 1'b0;
  logic              scrub_busy, ded_irq;
  logic [CNT_W-1:0]  sec_count, ded_count;
  logic [ADDR_W-1:0] ded_addr;

  int checks = 0;
  int errors = 0;
  int plan   = 0;  // ECC response for the next scrub read: 0 clean, 1 sec, 2 ded, 3 flags without valid

  ecc_scrub_scheduler #(
    .ADDR_W(ADDR_W), .INTERVAL(INTERVAL), .MAX_DEFER(MAX_DEFER), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_gnt(host_gnt),
    .scrub_en(scrub_en),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wb_sel(mem_wb_sel),
    .ecc_valid(ecc_valid), .ecc_sec(ecc_sec), .ecc_ded(ecc_ded),
    .scrub_busy(scrub_busy), .sec_count(sec_count), .ded_count(ded_count),
    .ded_irq(ded_irq), .ded_addr(ded_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the array answers any read of the previous cycle with ECC flags.
  task automatic tick();
    logic rd, sr;
    #1;
    rd = mem_en && !mem_we;
    sr = rd && !host_gnt;
    @(posedge clk);
    #1;
    ecc_valid = 1'b0; ecc_sec = 1'b0; ecc_ded = 1'b0;
    if (sr) begin
      ecc_valid = (plan != 3);
      ecc_sec   = (plan == 1) || (plan == 3);
      ecc_ded   = (plan == 2);
      plan      = 0;
    end else if (rd) begin
      ecc_valid = 1'b1;
      ecc_sec   = 1'($urandom);
      ecc_ded   = 1'($urandom);
    end
    #1;
  endtask

  task automatic wait_scrub(input string tag, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      tick();
      n++;
      found = mem_en && !host_gnt;
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL %s observed=no scrub access in %0d cycles expected=scrub access", tag, n);
    end
  endtask

  task automatic goto_row(input int r);
    int n;
    for (int k = 0; k < DEPTH + 2; k++) begin
      wait_scrub("goto_wait", n);
      if (int'(mem_addr) == r) break;
    end
    chk("goto_row", 32'(mem_addr), 32'(r));
  endtask

  // Model state for the random phase
  int  exp_row, wb_row, rd_row, cur_plan, m_sec, m_ded, m_ded_addr;
  bit  chk_now, irq_exp, gnt_prev, sa;
  int  n, r0;

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_host_gnt", host_gnt, 0);
    chk("rst_busy", scrub_busy, 0);
    chk("rst_sec", sec_count, 0);
    chk("rst_ded", ded_count, 0);
    chk("rst_irq", ded_irq, 0);
    chk("rst_ded_addr", ded_addr, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // Periodic clean scrub walk with wrap
    rst = 1'b0; scrub_en = 1'b1;
    wait_scrub("walk_first", n);
    chk("walk_first_lat", 32'(n), 32'(INTERVAL + 1));
    chk("walk_first_row", mem_addr, 0);
    chk("walk_first_we", mem_we, 0);
    for (int k = 1; k <= DEPTH; k++) begin
      wait_scrub("walk", n);
      chk("walk_period", 32'(n), 32'(INTERVAL + 2));
      chk("walk_row", 32'(mem_addr), 32'(k % DEPTH));
    end

    // SEC at row 5 -> write-back
    goto_row(5);
    plan = 1;
    tick();
    chk("sec_chk_busy", scrub_busy, 1);
    tick();
    chk("sec_wb_en", mem_en, 1);
    chk("sec_wb_we", mem_we, 1);
    chk("sec_wb_sel", mem_wb_sel, 1);
    chk("sec_wb_addr", mem_addr, 5);
    chk("sec_count1", sec_count, 1);

    // DED at row 9 -> log, no write-back
    goto_row(9);
    plan = 2;
    tick();
    tick();
    chk("ded_irq_pulse", ded_irq, 1);
    chk("ded_addr", ded_addr, 9);
    chk("ded_count1", ded_count, 1);
    chk("ded_no_wb", mem_en, 0);
    chk("ded_idle_busy", scrub_busy, 0);
    tick();
    chk("ded_irq_low", ded_irq, 0);
    wait_scrub("ded_next", n);
    chk("ded_next_row", mem_addr, 10);
    chk("ded_next_we", mem_we, 0);

    // Host holds request for 40 cycles; scrub forces exactly one slot
    tick();
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'd77;
    for (int i = 0; i < 40; i++) begin
      #1;
      chk("defer_gnt", host_gnt, (i == FORCE_I) ? 0 : 1);
      if (i == FORCE_I) begin
        chk("defer_forced_en", mem_en, 1);
        chk("defer_forced_addr", mem_addr, 11);
      end else begin
        chk("defer_host_addr", mem_addr, 77);
      end
      tick();
    end
    host_req = 1'b0;
    #1;
    chk("defer_release_scrub", mem_en && !host_gnt, 1);
    chk("defer_release_row", mem_addr, 12);

    // Reset while write-back is blocked
    plan = 1;
    tick();
    host_req = 1'b1; host_we = 1'b1; host_addr = 7'd13;
    tick();
    chk("wb_blocked_busy", scrub_busy, 1);
    chk("wb_blocked_sel", mem_wb_sel, 0);
    chk("wb_blocked_gnt", host_gnt, 1);
    chk("wb_sec_count2", sec_count, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", host_gnt, 0);
    chk("mid_rst_en", mem_en, 0);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_sel", mem_wb_sel, 0);
    chk("mid_rst_busy", scrub_busy, 0);
    chk("mid_rst_sec", sec_count, 0);
    chk("mid_rst_ded", ded_count, 0);
    chk("mid_rst_ded_addr", ded_addr, 0);
    host_req = 1'b0; host_we = 1'b0; host_addr = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold_we", mem_we, 0);
    end
    rst = 1'b0;
    wait_scrub("post_rst", n);
    chk("post_rst_lat", 32'(n), 32'(INTERVAL + 1));
    chk("post_rst_row", mem_addr, 0);
    chk("post_rst_we", mem_we, 0);

    // SEC at row 3 superseded by a host write before the write-back slot
    goto_row(3);
    plan = 1;
    tick();
    tick();
    host_req = 1'b1; host_we = 1'b1; host_addr = 7'd3;
    #1;
    chk("cancel_gnt", host_gnt, 1);
    chk("cancel_sel", mem_wb_sel, 0);
    chk("cancel_addr", mem_addr, 3);
    tick();
    host_req = 1'b0; host_we = 1'b0;
    #1;
    chk("cancel_sec_count", sec_count, 1);
    wait_scrub("cancel_next", n);
    chk("cancel_next_row", mem_addr, 4);
    chk("cancel_next_we", mem_we, 0);
    chk("cancel_next_sel", mem_wb_sel, 0);

    // Random host traffic and ECC responses against the transaction model
    exp_row = 4; wb_row = -1; rd_row = 4; cur_plan = 0; chk_now = 1'b1;
    m_sec = 1; m_ded = 0; m_ded_addr = 0; irq_exp = 1'b0; gnt_prev = 1'b0;
    for (int it = 0; it < 3000; it++) begin
      tick();
      if (!host_req || gnt_prev) begin
        if ($urandom_range(0, 9) < 4) begin
          host_req = 1'b1;
          host_we  = 1'($urandom);
          if ($urandom_range(0, 2) == 0) host_addr = ADDR_W'((wb_row >= 0) ? wb_row : exp_row);
          else                            host_addr = ADDR_W'($urandom);
        end else begin
          host_req = 1'b0;
        end
      end
      if ($urandom_range(0, 199) == 0) scrub_en = !scrub_en;
      #1;
      sa = mem_en && !host_gnt;
      chk("rnd_irq", ded_irq, irq_exp);
      if (irq_exp) chk("rnd_ded_addr", 32'(ded_addr), 32'(m_ded_addr));
      chk("rnd_sec_count", 32'(sec_count), 32'(m_sec));
      chk("rnd_ded_count", 32'(ded_count), 32'(m_ded));
      if (chk_now || wb_row >= 0) chk("rnd_busy", scrub_busy, 1);
      irq_exp = 1'b0;
      if (chk_now) begin
        chk_now = 1'b0;
        if (cur_plan == 1) begin
          m_sec  = (m_sec == SAT) ? SAT : m_sec + 1;
          wb_row = rd_row;
        end else if (cur_plan == 2) begin
          m_ded      = (m_ded == SAT) ? SAT : m_ded + 1;
          m_ded_addr = rd_row;
          irq_exp    = 1'b1;
          exp_row    = (rd_row + 1) % DEPTH;
        end else begin
          exp_row = (rd_row + 1) % DEPTH;
        end
      end
      if (wb_row >= 0 && host_gnt && host_we && int'(host_addr) == wb_row) begin
        exp_row = (wb_row + 1) % DEPTH;
        wb_row  = -1;
      end
      if (host_gnt) begin
        chk("rnd_gnt_req", host_req, 1);
        chk("rnd_host_addr", 32'(mem_addr), 32'(host_addr));
        chk("rnd_host_we", mem_we, host_we);
        chk("rnd_host_sel", mem_wb_sel, 0);
      end else if (host_req) begin
        chk("rnd_forced_slot", sa, 1);
      end
      if (sa) begin
        if (wb_row >= 0) begin
          chk("rnd_wb_we", mem_we, 1);
          chk("rnd_wb_sel", mem_wb_sel, 1);
          chk("rnd_wb_row", 32'(mem_addr), 32'(wb_row));
          exp_row = (wb_row + 1) % DEPTH;
          wb_row  = -1;
        end else begin
          chk("rnd_rd_we", mem_we, 0);
          chk("rnd_rd_sel", mem_wb_sel, 0);
          chk("rnd_rd_row", 32'(mem_addr), 32'(exp_row));
          rd_row   = exp_row;
          chk_now  = 1'b1;
          cur_plan = $urandom_range(0, 3);
          plan     = cur_plan;
        end
      end
      gnt_prev = host_gnt;
    end

    r0 = errors;
    $display("CHECKS %0d ERRORS %0d", checks, r0);
    $finish;
  end

endmodule
